alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 3-bit combinational ALU.
- Generalised operand width; operation set widened to 8 ops, including an iterative shift-add multiply.
- Adds a valid/ready handshake on input and output, an internal accumulator usable as operand A, and zero/carry flags.
- Sits between the pin-level operand capture logic and the output mux of the tile.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on input and output sides.
// master = operand source and result consumer, slave = the ALU.
interface alu_seq_if #(
   parameter int W = 3
) ();
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic [2:0]     sel_in;
   logic           acc_sel;
   logic           in_valid;
   logic           in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] alu_out;
   logic           zero_flag;
   logic           carry_flag;

   modport master (
      output a_in, b_in, sel_in, acc_sel, in_valid, out_ready,
      input  in_ready, out_valid, alu_out, zero_flag, carry_flag
   );

   modport slave (
      input  a_in, b_in, sel_in, acc_sel, in_valid, out_ready,
      output in_ready, out_valid, alu_out, zero_flag, carry_flag
   );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshake, accumulator operand and zero/carry flags.
// Single-cycle ops complete on acceptance; MUL iterates one multiplier bit per cycle.
module alu_seq #(
   parameter  int W   = 3,
   localparam int SHW = $clog2(W)
) (
   input logic       clk,
   input logic       rst,
   alu_seq_if.slave  bus
);
   // Wide enough that no bit is lost for any shift amount the SHW-bit field can encode.
   localparam int SHX = W + (1 << SHW);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t         state_reg, state_next;
   logic [W-1:0]   acc_reg;
   logic [W-1:0]   mplier_reg;
   logic [2*W-1:0] mcand_reg;
   logic [2*W-1:0] prod_reg;
   logic [SHW:0]   cnt_reg;
   logic [2*W-1:0] alu_out_reg;
   logic           zero_reg;
   logic           carry_reg;

   logic [W-1:0]   op_a;
   logic [W-1:0]   xor_v, and_v, or_v;
   logic [W:0]     add_v, sub_v;
   logic [SHX-1:0] shl_full;
   logic [2*W-1:0] res_next;
   logic           carry_next;
   logic [2*W-1:0] prod_next;
   logic           mul_last;
   logic           accept, retire;
   logic           in_ready_c, out_valid_c;

   assign op_a = bus.acc_sel ? acc_reg : bus.a_in;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign xor_v[gi] = op_a[gi] ^ bus.b_in[gi];
      assign and_v[gi] = op_a[gi] & bus.b_in[gi];
      assign or_v[gi]  = op_a[gi] | bus.b_in[gi];
   end

   assign add_v    = {1'b0, op_a} + {1'b0, bus.b_in};
   assign sub_v    = {1'b0, op_a} - {1'b0, bus.b_in};
   assign shl_full = {{(SHX-W){1'b0}}, op_a} << bus.b_in[SHW-1:0];

   always_comb begin
      res_next   = '0;
      carry_next = 1'b0;
      case (bus.sel_in)
         3'd0: begin
            res_next   = {{(W-1){1'b0}}, sub_v};
            carry_next = (op_a < bus.b_in);
         end
         3'd1: begin
            res_next   = {{(W-1){1'b0}}, add_v};
            carry_next = add_v[W];
         end
         3'd2: res_next = {{W{1'b0}}, xor_v};
         3'd3: res_next = {{W{1'b0}}, and_v};
         3'd4: res_next = {{W{1'b0}}, or_v};
         3'd5: begin
            res_next   = {{W{1'b0}}, shl_full[W-1:0]};
            carry_next = |shl_full[SHX-1:W];
         end
         3'd7: res_next = {{W{1'b0}}, op_a};
         default: ;
      endcase
   end

   assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign mul_last  = (cnt_reg == (SHW+1)'(W-1));

   always_comb begin
      state_next  = state_reg;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid)
               state_next = (bus.sel_in == 3'd6) ? MUL : DONE;
         end
         MUL: begin
            if (mul_last)
               state_next = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = (state_reg == IDLE) && bus.in_valid;
   assign retire = (state_reg == DONE) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg     <= '0;
         alu_out_reg <= '0;
         zero_reg    <= 1'b0;
         carry_reg   <= 1'b0;
         prod_reg    <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         cnt_reg     <= '0;
      end else begin
         if (accept) begin
            if (bus.sel_in == 3'd6) begin
               prod_reg   <= '0;
               mcand_reg  <= {{W{1'b0}}, op_a};
               mplier_reg <= bus.b_in;
               cnt_reg    <= '0;
            end else begin
               alu_out_reg <= res_next;
               zero_reg    <= (res_next == '0);
               carry_reg   <= carry_next;
            end
         end
         if (state_reg == MUL) begin
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (mul_last) begin
               alu_out_reg <= prod_next;
               zero_reg    <= (prod_next == '0);
               carry_reg   <= |prod_next[2*W-1:W];
            end
         end
         // The retired result's low bits become the next accumulator operand.
         if (retire)
            acc_reg <= alu_out_reg[W-1:0];
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.alu_out    = alu_out_reg;
   assign bus.zero_flag  = zero_reg;
   assign bus.carry_flag = carry_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at W=3; inputs driven and outputs sampled on the falling edge.
module tb_alu_seq;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   alu_seq_if #(.W(W)) bus ();

   alu_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Presents one op for a single cycle; returns at the falling edge after acceptance.
   task automatic send(input logic [2:0] sel, input logic [2:0] a, input logic [2:0] b,
                       input logic as);
      @(negedge clk);
      bus.sel_in   = sel;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.acc_sel  = as;
      bus.in_valid = 1'b1;
      chk("in_ready_at_send", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_res(input string tag, input int res, input logic z, input logic c);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_out"},   32'(bus.alu_out), 32'(res));
      chk({tag, "_zero"},  32'(bus.zero_flag), 32'(z));
      chk({tag, "_carry"}, 32'(bus.carry_flag), 32'(c));
   endtask

   task automatic retire(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_ret_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_ret_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   // MUL busy window: cycles t+1..t+3 show neither ready nor valid.
   task automatic mul_busy(input string tag);
      for (int i = 1; i <= W; i++) begin
         chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
         chk({tag, "_busy_valid"}, 32'(bus.out_valid), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_done_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.sel_in    = '0;
      bus.acc_sel   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu_out",   32'(bus.alu_out), 32'd0);
      chk("rst_zero",      32'(bus.zero_flag), 32'd0);
      chk("rst_carry",     32'(bus.carry_flag), 32'd0);
      rst = 1'b0;

      send(3'd0, 3'd3, 3'd5, 1'b0); expect_res("sub_3_5", 14, 1'b0, 1'b1); retire("sub_3_5");
      send(3'd0, 3'd5, 3'd3, 1'b0); expect_res("sub_5_3", 2, 1'b0, 1'b0);  retire("sub_5_3");
      send(3'd1, 3'd7, 3'd7, 1'b0); expect_res("add_7_7", 14, 1'b0, 1'b1); retire("add_7_7");
      send(3'd1, 3'd0, 3'd0, 1'b0); expect_res("add_0_0", 0, 1'b1, 1'b0);  retire("add_0_0");
      send(3'd3, 3'd6, 3'd3, 1'b0); expect_res("and_6_3", 2, 1'b0, 1'b0);  retire("and_6_3");
      send(3'd4, 3'd4, 3'd1, 1'b0); expect_res("or_4_1", 5, 1'b0, 1'b0);   retire("or_4_1");
      send(3'd7, 3'd5, 3'd2, 1'b0); expect_res("pass_5", 5, 1'b0, 1'b0);   retire("pass_5");
      send(3'd5, 3'd6, 3'd2, 1'b0); expect_res("shl_6_2", 0, 1'b1, 1'b1);  retire("shl_6_2");

      send(3'd6, 3'd7, 3'd7, 1'b0); mul_busy("mul_7_7");
      expect_res("mul_7_7", 49, 1'b0, 1'b1); retire("mul_7_7");
      send(3'd6, 3'd2, 3'd3, 1'b0); mul_busy("mul_2_3");
      expect_res("mul_2_3", 6, 1'b0, 1'b0); retire("mul_2_3");

      // Backpressure: a competing op held on in_valid must be ignored while DONE.
      send(3'd2, 3'd5, 3'd3, 1'b0);
      bus.sel_in   = 3'd1;
      bus.a_in     = 3'd1;
      bus.b_in     = 3'd1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         expect_res("xor_hold", 6, 1'b0, 1'b0);
         chk("xor_hold_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      retire("xor_hold");
      @(negedge clk);
      chk("xor_no_ghost", 32'(bus.out_valid), 32'd0);

      // Accumulator chain: 2+3=5, acc+4=9, acc(=1)<<1=2.
      send(3'd1, 3'd2, 3'd3, 1'b0); expect_res("chain_add", 5, 1'b0, 1'b0); retire("chain_add");
      send(3'd1, 3'd7, 3'd4, 1'b1); expect_res("chain_acc", 9, 1'b0, 1'b1); retire("chain_acc");
      send(3'd5, 3'd7, 3'd1, 1'b1); expect_res("chain_shl", 2, 1'b0, 1'b0); retire("chain_shl");

      // Reset during the second MUL cycle discards the op and clears acc.
      send(3'd6, 3'd7, 3'd7, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmul_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rstmul_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstmul_alu_out",   32'(bus.alu_out), 32'd0);
      repeat (3) @(negedge clk);
      chk("rstmul_stays_idle", 32'(bus.out_valid), 32'd0);
      send(3'd7, 3'd5, 3'd0, 1'b1); expect_res("pass_acc0", 0, 1'b1, 1'b0); retire("pass_acc0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
